// File: rtl/dp_arbiter.sv
// Two-requester round-robin front end for a shared datapath of latency LAT.
// Results return in issue order through a {valid,id} tag pipeline.
module dp_arbiter #(
  parameter int N   = 16,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [2:0]   req0_op,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [2:0]   req1_op,
  output logic [N-1:0] dp_a,
  output logic [N-1:0] dp_b,
  output logic [2:0]   dp_opcode,
  output logic         dp_issue,
  input  logic [N-1:0] dp_y,
  input  logic         dp_co,
  output logic         res0_valid,
  output logic         res1_valid,
  output logic [N-1:0] res_y,
  output logic         res_co,
  output logic         busy
);
  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
  } req_t;

  req_t       req0, req1, win_req;
  logic       last_grant, winner, xfer;
  logic [LAT:0] vld_pipe, id_pipe;
  logic       res_vld, res_id;

  assign req0 = {req0_a, req0_b, req0_op};
  assign req1 = {req1_a, req1_b, req1_op};

  // winner is the requester id; on contention the one not granted last wins
  assign winner     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready = rst_n & en & req0_valid & ~winner;
  assign req1_ready = rst_n & en & req1_valid & winner;
  assign xfer       = req0_ready | req1_ready;
  assign win_req    = winner ? req1 : req0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      dp_a       <= '0;
      dp_b       <= '0;
      dp_opcode  <= '0;
      vld_pipe   <= '0;
      id_pipe    <= '0;
      res_vld    <= 1'b0;
      res_id     <= 1'b0;
      res_y      <= '0;
      res_co     <= 1'b0;
    end else begin
      if (xfer) begin
        last_grant <= winner;
        dp_a       <= win_req.a;
        dp_b       <= win_req.b;
        dp_opcode  <= win_req.op;
      end
      vld_pipe[0] <= xfer;
      id_pipe[0]  <= winner;
      for (int k = 1; k <= LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        id_pipe[k]  <= id_pipe[k-1];
      end
      // last tag stage lines up with the datapath result of the same op
      res_vld <= vld_pipe[LAT];
      res_id  <= id_pipe[LAT];
      if (vld_pipe[LAT]) begin
        res_y  <= dp_y;
        res_co <= dp_co;
      end
    end
  end

  assign dp_issue   = vld_pipe[0];
  assign res0_valid = res_vld & ~res_id;
  assign res1_valid = res_vld & res_id;
  assign busy       = (|vld_pipe) | res_vld;
endmodule

// File: tb/tb_dp_arbiter.sv
// Bench for dp_arbiter: round-robin/readiness model, result scoreboard,
// a vector table for arbitration patterns and directed multi-cycle sequences.
module tb_dp_arbiter;
  localparam int N   = 16;
  localparam int LAT = 1;

  logic         clk = 1'b0;
  logic         rst_n, en, req0_valid, req1_valid, req0_ready, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b, dp_a, dp_b, dp_y, res_y;
  logic [2:0]   req0_op, req1_op, dp_opcode;
  logic         dp_issue, dp_co, res0_valid, res1_valid, res_co, busy;

  dp_arbiter #(.N(N), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .dp_a(dp_a), .dp_b(dp_b), .dp_opcode(dp_opcode), .dp_issue(dp_issue),
    .dp_y(dp_y), .dp_co(dp_co),
    .res0_valid(res0_valid), .res1_valid(res1_valid),
    .res_y(res_y), .res_co(res_co), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [N:0] dp_fn(logic [N-1:0] a, logic [N-1:0] b, logic [2:0] op);
    logic [N-1:0] bs;
    bs = op[2] ? '0 : (op[1] ? ~b : b);
    return {1'b0, a} + {1'b0, bs} + {{N{1'b0}}, op[0]};
  endfunction

  // external datapath with one cycle of latency
  logic [N:0] dp_r = '0;
  always @(posedge clk) dp_r <= dp_fn(dp_a, dp_b, dp_opcode);
  assign {dp_co, dp_y} = dp_r;

  int total = 0, bad = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { logic id; logic [N:0] res; int due; } sb_t;
  sb_t        q[$];
  int         cyc = 0;
  logic       mlg = 1'b1, prev_xfer = 1'b0;
  logic [2*N+2:0] prev_ops = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // model of arbitration, issue, busy and result ordering
  always @(negedge clk) begin
    logic w, e0, e1;
    if (!rst_n) begin
      chk("reset_outs", {req0_ready, req1_ready, dp_issue, res0_valid, res1_valid, busy,
                         res_co, res_y, dp_opcode}, '0);
      chk("reset_ops", {dp_a, dp_b}, '0);
      q.delete();
      mlg = 1'b1;
      prev_xfer = 1'b0;
    end else begin
      w  = (req0_valid && req1_valid) ? ~mlg : req1_valid;
      e0 = en & req0_valid & ~w;
      e1 = en & req1_valid & w;
      chk("ready", {req0_ready, req1_ready}, {e0, e1});
      chk("dp_issue", dp_issue, prev_xfer);
      if (prev_xfer) chk("dp_ops", {dp_a, dp_b, dp_opcode}, prev_ops);
      chk("busy", busy, q.size() > 0);
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("res_valid", {res0_valid, res1_valid}, q[0].id ? 2'b01 : 2'b10);
        chk("res_val", {res_co, res_y}, q[0].res);
        void'(q.pop_front());
      end else begin
        chk("res_idle", {res0_valid, res1_valid}, 2'b00);
      end
      if (e0 | e1) begin
        prev_ops = w ? {req1_a, req1_b, req1_op} : {req0_a, req0_b, req0_op};
        q.push_back('{id: w, res: w ? dp_fn(req1_a, req1_b, req1_op)
                                    : dp_fn(req0_a, req0_b, req0_op),
                      due: cyc + LAT + 2});
        mlg = w;
      end
      prev_xfer = e0 | e1;
    end
  end

  // one request with constant expected result, walked cycle by cycle
  task automatic directed(logic id, logic [N-1:0] a, logic [N-1:0] b, logic [2:0] op,
                          logic [N-1:0] ey, logic eco);
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
    @(negedge clk);
    chk("d_ready", {req0_ready, req1_ready}, id ? 2'b01 : 2'b10);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    chk("d_issue", {dp_issue, busy}, 2'b11);
    repeat (LAT) begin
      @(posedge clk); #1; @(negedge clk);
      chk("d_wait", {res0_valid, res1_valid, busy}, 3'b001);
    end
    @(posedge clk); #1; @(negedge clk);
    chk("d_res_valid", {res0_valid, res1_valid, busy}, id ? 3'b011 : 3'b101);
    chk("d_res", {res_co, res_y}, {eco, ey});
    @(posedge clk); #1; @(negedge clk);
    chk("d_idle", {res0_valid, res1_valid, busy}, 3'b000);
  endtask

  typedef struct { logic en, v0, v1, e0, e1; } vec_t;
  vec_t tbl[$];
  int   cnt0 = 0, cnt1 = 0;

  initial begin
    tbl = '{
      '{1,1,1,1,0}, '{1,1,1,0,1}, '{1,1,1,1,0}, '{1,1,1,0,1}, '{1,1,1,1,0},
      '{0,1,1,0,0}, '{0,1,1,0,0}, '{0,1,1,0,0}, '{1,1,1,0,1}, '{1,0,1,0,1},
      '{1,0,1,0,1}, '{1,1,1,1,0}, '{1,1,0,1,0}, '{0,0,0,0,0}, '{1,0,0,0,0},
      '{1,0,0,0,0}, '{1,0,0,0,0}};
    rst_n = 0; en = 1;
    req0_valid = 1; req0_a = 16'd5; req0_b = 16'd3; req0_op = 3'b000;
    req1_valid = 1; req1_a = 16'd7; req1_b = 16'd1; req1_op = 3'b001;
    repeat (3) @(posedge clk);
    #1; rst_n = 1; req1_valid = 0;
    // first edge after reset release accepts
    directed(0, 16'd5, 16'd3, 3'b000, 16'd8, 1'b0);
    @(posedge clk); #1;
    directed(1, 16'd3, 16'd5, 3'b011, 16'hFFFE, 1'b0);

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      en = tbl[i].en; req0_valid = tbl[i].v0; req1_valid = tbl[i].v1;
      req0_a = 16'h1000 + 16'(cnt0 * 7); req0_b = 16'(cnt0 * 13); req0_op = 3'(cnt0);
      req1_a = 16'h8000 ^ 16'(cnt1 * 11); req1_b = 16'hFFF0 - 16'(cnt1); req1_op = 3'(7 - cnt1);
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), {req0_ready, req1_ready}, {tbl[i].e0, tbl[i].e1});
      if (tbl[i].e0) cnt0++;
      if (tbl[i].e1) cnt1++;
    end

    // reset while an op is in flight: no result may follow
    @(posedge clk); #1;
    en = 1; req0_valid = 1; req0_a = 16'd9; req0_b = 16'd9; req0_op = 3'b000;
    @(negedge clk);
    chk("r_accept", req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 0; rst_n = 0;
    @(negedge clk);
    chk("r_busy", busy, 1'b0);
    @(posedge clk); #1; rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      chk("r_quiet", {res0_valid, res1_valid, busy}, 3'b000);
      @(posedge clk); #1;
    end
    directed(0, 16'hFFFF, 16'd1, 3'b000, 16'h0000, 1'b1);
    @(posedge clk); #1;
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dp_arbiter.md
DP_ARBITER -- requirements
Module: dp_arbiter

Interface
REQ-001 Parameter N, default 16: operand and result width in bits.
REQ-002 Parameter LAT, default 1: datapath latency in cycles from issue to result, legal range 0..3.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 en  input  1: arbitration enable; when low, no new request is accepted.
REQ-006 req0_valid / req1_valid  input  1: requester has an operation pending.
REQ-007 req0_ready / req1_ready  output  1: operation accepted at this rising edge.
REQ-008 req0_a, req0_b / req1_a, req1_b  input  N each: signed operands.
REQ-009 req0_op / req1_op  input  3: datapath opcode.
REQ-010 dp_a, dp_b  output  N: registered operands to the shared datapath.
REQ-011 dp_opcode  output  3: registered opcode to the shared datapath.
REQ-012 dp_issue  output  1: one-cycle strobe; dp_a, dp_b and dp_opcode are valid this cycle.
REQ-013 dp_y  input  N: datapath result.
REQ-014 dp_co  input  1: datapath carry-out.
REQ-015 res0_valid / res1_valid  output  1: one-cycle result strobe per requester; there is no backpressure.
REQ-016 res_y  output  N, res_co  output  1: registered result, shared by both result ports.
REQ-017 busy  output  1: high while any accepted operation has not yet produced res*_valid.

Function
REQ-018 Handshake: a request transfers at an edge where reqX_valid and reqX_ready are both high; requesters shall hold a, b and op stable while valid is high and ready is low.
REQ-019 reqX_ready shall be combinational and high only when en=1, reqX_valid=1 and X is the arbitration winner; at most one ready is high per cycle.
REQ-020 Arbitration shall be round-robin with a 1-bit pointer last_grant:
- sole valid requester wins;
- when both are valid, the requester other than last_grant wins;
- last_grant updates only on a transfer.
REQ-021 On a transfer, the winner's a, b and op shall be registered into dp_a, dp_b and dp_opcode, and dp_issue shall be high for exactly the following cycle (cycle I).
REQ-022 Without a transfer, dp_issue shall be 0 and dp_a, dp_b and dp_opcode shall hold their previous values.
REQ-023 Throughput: one transfer per cycle is allowed; back-to-back issues shall be supported at full rate.
REQ-024 Tag pipeline: a LAT+1 stage shift register of {valid, requester-id} shall be loaded at issue and shall track each operation.
REQ-025 dp_y and dp_co shall be sampled at the end of cycle I+LAT.
REQ-026 res_y, res_co and the matching resX_valid shall be high in cycle I+LAT+1, for exactly one cycle.
REQ-027 Total latency: a transfer at edge t yields its result strobe in cycle t+LAT+2.
REQ-028 Results shall be returned in issue order, with no reordering and no loss.
REQ-029 The arbiter shall not alter operands or opcode and shall pass dp_y and dp_co through unmodified; the opcode value is not checked.
REQ-030 busy shall equal the OR of all tag-pipeline valid bits and the result-register valid.
REQ-031 When en=0, accepts shall stop but in-flight operations shall still complete and strobe their results.
REQ-032 A simultaneous transfer and result strobe in the same cycle shall both be handled, with neither stalled.

Reset
REQ-033 While rst_n=0, outputs shall immediately be:
- req*_ready=0, dp_issue=0, res*_valid=0, busy=0;
- dp_a=0, dp_b=0, dp_opcode=0, res_y=0, res_co=0;
- last_grant=1, so that req0 wins the first contention.
REQ-034 Reset mid-operation shall discard all in-flight tags; no res*_valid shall be emitted for operations accepted before reset.
REQ-035 The first transfer shall be possible at the first rising edge after rst_n deasserts.

Verification (N=16, LAT=1, datapath model: Y = A + (op[2] ? 0 : (op[1] ? ~B : B)) + op[0])
REQ-036 req0: a=5, b=3, op=000, accepted at edge t -> dp_issue in cycle t+1; res0_valid in cycle t+3 with res_y=8, res_co=0.
REQ-037 req1: a=3, b=5, op=011 -> res1_valid with res_y=0xFFFE, res_co=0; busy high from t+1 through t+3.
REQ-038 Both valid continuously after reset, distinct operands -> grants alternate req0, req1, req0, ...; results arrive every cycle with ids matching issue order.
REQ-039 en=0 with both requesters valid -> no ready and no dp_issue; an op in flight still strobes its result; en=1 resumes on the next edge.
REQ-040 rst_n pulsed low the cycle after an accept -> no res*_valid follows and busy=0; a new request after reset completes normally.
REQ-041 a=0xFFFF, b=1, op=000 -> res_y=0x0000, res_co=1.
